// File: rtl/flash_boot_loader.sv
// Boot-time SPI flash copier: issues a READ (0x03) in mode 0, streams BOOT_WORDS
// little-endian words into the imem write port, then raises a sticky boot_done.
module flash_boot_loader #(
  parameter int unsigned CLK_DIV    = 2,
  parameter logic [23:0] FLASH_BASE = 24'h0,
  parameter int unsigned BOOT_WORDS = 1024,
  parameter int unsigned IMEM_DEPTH = 32 * 1024,
  localparam int unsigned ADDR_W    = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_boot_en,
  output logic              o_flash_sclk,
  output logic              o_flash_cs_n,
  output logic              o_flash_mosi,
  input  logic              i_flash_miso,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_boot_done
);

  localparam int unsigned       DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(BOOT_WORDS - 1);
  localparam logic [31:0]       CMD_WORD  = {8'h03, FLASH_BASE};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]        state_q,  state_d;
  logic [DIV_W-1:0]  div_q,    div_d;
  logic [4:0]        bit_q,    bit_d;
  logic [ADDR_W-1:0] word_q,   word_d;
  logic [31:0]       cmd_sh_q, cmd_sh_d;
  logic [31:0]       rx_q,     rx_d;
  logic              pend_q,   pend_d;
  logic              fin_q,    fin_d;
  logic              sclk_q,   sclk_d;
  logic              cs_n_q,   cs_n_d;
  logic              mosi_q,   mosi_d;
  logic              we_q,     we_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [31:0]       wdata_q,  wdata_d;
  logic              done_q,   done_d;
  logic              tick_s;

  // Flash bytes arrive MSB-first; byte0 belongs in the least significant lane.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Next-state logic: SCLK divider, command shifter, word assembly and imem write.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    word_d   = word_q;
    cmd_sh_d = cmd_sh_q;
    rx_d     = rx_q;
    pend_d   = pend_q;
    fin_d    = fin_q;
    sclk_d   = sclk_q;
    cs_n_d   = cs_n_q;
    mosi_d   = mosi_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = done_q;
    tick_s   = (div_q == DIV_LAST);

    case (state_q)
      ST_IDLE: begin
        sclk_d = 1'b0;
        div_d  = '0;
        bit_d  = 5'd0;
        word_d = '0;
        pend_d = 1'b0;
        fin_d  = 1'b0;
        if (i_boot_en) begin
          state_d  = ST_CMD;
          cs_n_d   = 1'b0;
          mosi_d   = CMD_WORD[31];
          cmd_sh_d = {CMD_WORD[30:0], 1'b0};
          done_d   = 1'b0;
        end else begin
          state_d = ST_DONE;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      ST_CMD, ST_DATA: begin
        // A completed word is written one edge after its last sample; the
        // next sample is always at least two edges away, so no overlap.
        if (pend_q) begin
          we_d    = 1'b1;
          addr_d  = word_q;
          wdata_d = byte_swap(rx_q);
          pend_d  = 1'b0;
          if (word_q == LAST_WORD) begin
            fin_d = 1'b1;
          end else begin
            word_d = word_q + ADDR_W'(1);
          end
        end else begin
          pend_d = pend_q;
        end

        if (tick_s) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            if (state_q == ST_CMD) begin
              mosi_d   = cmd_sh_q[31];
              cmd_sh_d = {cmd_sh_q[30:0], 1'b0};
            end else begin
              mosi_d = 1'b0;
            end
          end else begin
            bit_d = bit_q + 5'd1;
            if (state_q == ST_CMD) begin
              if (bit_q == 5'd31) begin
                state_d = ST_DATA;
              end else begin
                state_d = ST_CMD;
              end
            end else begin
              rx_d = {rx_q[30:0], i_flash_miso};
              if (bit_q == 5'd31) begin
                pend_d = 1'b1;
              end else begin
                pend_d = 1'b0;
              end
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end

        // Final word has been written: release the flash on this edge.
        if (fin_q) begin
          state_d = ST_DONE;
          cs_n_d  = 1'b1;
          sclk_d  = 1'b0;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          div_d   = '0;
        end else begin
          done_d = 1'b0;
        end
      end

      ST_DONE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        done_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      bit_q    <= 5'd0;
      word_q   <= '0;
      cmd_sh_q <= 32'd0;
      rx_q     <= 32'd0;
      pend_q   <= 1'b0;
      fin_q    <= 1'b0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      word_q   <= word_d;
      cmd_sh_q <= cmd_sh_d;
      rx_q     <= rx_d;
      pend_q   <= pend_d;
      fin_q    <= fin_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      mosi_q   <= mosi_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
    end
  end

  assign o_flash_sclk = sclk_q;
  assign o_flash_cs_n = cs_n_q;
  assign o_flash_mosi = mosi_q;
  assign o_imem_we    = we_q;
  assign o_imem_addr  = addr_q;
  assign o_imem_wdata = wdata_q;
  assign o_boot_done  = done_q;

endmodule

// File: tb/tb_flash_boot_loader.sv
// Directed bench for flash_boot_loader: three instances cover base config with a
// flash model, CLK_DIV=3 timing, and MISO tied high at CLK_DIV=1.
module tb_flash_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: CLK_DIV=2, BOOT_WORDS=4, FLASH_BASE=0x100000
  logic       reset_n_a, boot_en_a, sclk_a, cs_n_a, mosi_a, we_a, done_a;
  logic       miso_a = 1'b0;
  logic [3:0] addr_a;
  logic [31:0] wdata_a;
  // Instance B: CLK_DIV=3, BOOT_WORDS=2, MISO tied 0
  logic       reset_n_b, boot_en_b, sclk_b, cs_n_b, mosi_b, we_b, done_b, miso_b;
  logic [3:0] addr_b;
  logic [31:0] wdata_b;
  // Instance C: CLK_DIV=1, BOOT_WORDS=8, MISO tied 1
  logic       reset_n_c, boot_en_c, sclk_c, cs_n_c, mosi_c, we_c, done_c, miso_c;
  logic [2:0] addr_c;
  logic [31:0] wdata_c;

  assign miso_b = 1'b0;
  assign miso_c = 1'b1;

  flash_boot_loader #(.CLK_DIV(2), .FLASH_BASE(24'h100000), .BOOT_WORDS(4), .IMEM_DEPTH(16)) u_a (
    .clk(clk), .reset_n(reset_n_a), .i_boot_en(boot_en_a),
    .o_flash_sclk(sclk_a), .o_flash_cs_n(cs_n_a), .o_flash_mosi(mosi_a), .i_flash_miso(miso_a),
    .o_imem_we(we_a), .o_imem_addr(addr_a), .o_imem_wdata(wdata_a), .o_boot_done(done_a));

  flash_boot_loader #(.CLK_DIV(3), .FLASH_BASE(24'h0), .BOOT_WORDS(2), .IMEM_DEPTH(16)) u_b (
    .clk(clk), .reset_n(reset_n_b), .i_boot_en(boot_en_b),
    .o_flash_sclk(sclk_b), .o_flash_cs_n(cs_n_b), .o_flash_mosi(mosi_b), .i_flash_miso(miso_b),
    .o_imem_we(we_b), .o_imem_addr(addr_b), .o_imem_wdata(wdata_b), .o_boot_done(done_b));

  flash_boot_loader #(.CLK_DIV(1), .FLASH_BASE(24'h0), .BOOT_WORDS(8), .IMEM_DEPTH(8)) u_c (
    .clk(clk), .reset_n(reset_n_c), .i_boot_en(boot_en_c),
    .o_flash_sclk(sclk_c), .o_flash_cs_n(cs_n_c), .o_flash_mosi(mosi_c), .i_flash_miso(miso_c),
    .o_imem_we(we_c), .o_imem_addr(addr_c), .o_imem_wdata(wdata_c), .o_boot_done(done_c));

  logic [7:0]  flash_a [0:15] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                                  8'h78, 8'h56, 8'h34, 8'h12, 8'h81, 8'h0F, 8'hC3, 8'hA5};
  logic [31:0] imem_a [0:15];
  logic [3:0]  wr_log_a [0:63];
  logic [31:0] cmd_rx_a = 32'd0;
  logic        psclk_a = 1'b0;
  int fcnt_a = 0, rise_a = 0, wr_cnt_a = 0, mosi_err_a = 0;

  // SPI flash model for A: shifts in the command, drives data after each SCLK fall.
  always @(negedge clk) begin
    logic [7:0] b;
    int k;
    if (cs_n_a === 1'b1) begin
      fcnt_a = 0;
      miso_a = 1'b0;
    end else if (sclk_a && !psclk_a) begin
      if (fcnt_a < 32) cmd_rx_a = {cmd_rx_a[30:0], mosi_a};
      else if (mosi_a !== 1'b0) mosi_err_a++;
      fcnt_a++;
      rise_a++;
    end else if (!sclk_a && psclk_a && fcnt_a >= 32) begin
      k = fcnt_a - 32;
      b = flash_a[(k / 8) % 16];
      miso_a = b[7 - (k % 8)];
    end
    psclk_a = sclk_a;
    if (we_a === 1'b1) begin
      wr_log_a[wr_cnt_a % 64] = addr_a;
      imem_a[addr_a] = wdata_a;
      wr_cnt_a++;
    end
  end

  logic psclk_b = 1'b0, pcs_b = 1'b1, seen_low_b = 1'b0;
  int rise_b = 0, wr_cnt_b = 0, wbad_b = 0, run_b = 0, runs_b = 0, runv_b = 0, glitch_b = 0;

  // Monitor for B: SCLK phase lengths while CS is low, and CS continuity.
  always @(negedge clk) begin
    if (cs_n_b === 1'b0) begin
      if (pcs_b) run_b = 1;
      else if (sclk_b == psclk_b) run_b++;
      else begin
        if (run_b != 3) runv_b++;
        runs_b++;
        run_b = 1;
      end
      if (sclk_b && !psclk_b) rise_b++;
      seen_low_b = 1'b1;
    end else if (seen_low_b && !done_b) glitch_b++;
    psclk_b = sclk_b;
    pcs_b = cs_n_b;
    if (we_b === 1'b1) begin
      if (wdata_b !== 32'h0) wbad_b++;
      wr_cnt_b++;
    end
  end

  logic psclk_c = 1'b0, seen_done_c = 1'b0;
  int rise_c = 0, wr_cnt_c = 0, wbad_c = 0, aord_c = 0, drop_c = 0;

  // Monitor for C: write data/order and stickiness of done.
  always @(negedge clk) begin
    if (cs_n_c === 1'b0 && sclk_c && !psclk_c) rise_c++;
    psclk_c = sclk_c;
    if (we_c === 1'b1) begin
      if (wdata_c !== 32'hFFFF_FFFF) wbad_c++;
      if (int'(addr_c) != wr_cnt_c) aord_c++;
      wr_cnt_c++;
    end
    if (seen_done_c && done_c !== 1'b1) drop_c++;
    if (done_c === 1'b1) seen_done_c = 1'b1;
  end

  task automatic test_reset();
    reset_n_a = 1'b0; reset_n_b = 1'b0; reset_n_c = 1'b0;
    boot_en_a = 1'b1; boot_en_b = 1'b1; boot_en_c = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (sclk_a !== 1'b0) begin n_err++; $display("FAIL reset_sclk: got %b want 0", sclk_a); end
    n_vec++; if (cs_n_a !== 1'b1) begin n_err++; $display("FAIL reset_cs_n: got %b want 1", cs_n_a); end
    n_vec++; if (mosi_a !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b want 0", mosi_a); end
    n_vec++; if (we_a !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", we_a); end
    n_vec++; if (addr_a !== 4'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", addr_a); end
    n_vec++; if (wdata_a !== 32'd0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", wdata_a); end
    n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_a); end
    n_vec++; if (cs_n_b !== 1'b1 || done_b !== 1'b0) begin n_err++; $display("FAIL reset_b: cs_n=%b done=%b want 1/0", cs_n_b, done_b); end
    n_vec++; if (cs_n_c !== 1'b1 || done_c !== 1'b0) begin n_err++; $display("FAIL reset_c: cs_n=%b done=%b want 1/0", cs_n_c, done_c); end
  endtask

  task automatic test_skip();
    int r0, w0, bad;
    bit ok;
    boot_en_a = 1'b0;
    r0 = rise_a; w0 = wr_cnt_a; ok = 1'b0; bad = 0;
    reset_n_a = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin ok = 1'b1; break; end
    end
    n_vec++; if (!ok) begin n_err++; $display("FAIL skip_done: done=%b want 1 within 2 cycles", done_a); end
    repeat (20) begin
      @(negedge clk);
      if (cs_n_a !== 1'b1 || sclk_a !== 1'b0 || we_a !== 1'b0 || done_a !== 1'b1) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL skip_idle_pins: %0d bad cycles want 0", bad); end
    n_vec++; if (wr_cnt_a != w0) begin n_err++; $display("FAIL skip_no_we: %0d writes want 0", wr_cnt_a - w0); end
    n_vec++; if (rise_a != r0) begin n_err++; $display("FAIL skip_no_sclk: %0d rises want 0", rise_a - r0); end
  endtask

  task automatic test_boot();
    int r0, w0, m0;
    bit ok;
    logic [3:0] la;
    reset_n_a = 1'b0; boot_en_a = 1'b1;
    @(negedge clk);
    reset_n_a = 1'b1;
    r0 = rise_a; w0 = wr_cnt_a; m0 = mosi_err_a; ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 100) boot_en_a = 1'b0;
      if (done_a === 1'b1) begin ok = 1'b1; break; end
    end
    n_vec++; if (!ok) begin n_err++; $display("FAIL boot_timeout: done=%b want 1 within 3000 cycles", done_a); end
    n_vec++; if (cmd_rx_a !== 32'h0310_0000) begin n_err++; $display("FAIL boot_cmd: got %h want 03100000", cmd_rx_a); end
    n_vec++; if (mosi_err_a != m0) begin n_err++; $display("FAIL boot_mosi_data: %0d nonzero bits want 0", mosi_err_a - m0); end
    n_vec++; if (rise_a - r0 != 160) begin n_err++; $display("FAIL boot_rises: got %0d want 160", rise_a - r0); end
    n_vec++; if (wr_cnt_a - w0 != 4) begin n_err++; $display("FAIL boot_writes: got %0d want 4", wr_cnt_a - w0); end
    la = wr_log_a[(w0 + 3) % 64];
    n_vec++; if (la !== 4'd3) begin n_err++; $display("FAIL boot_last_addr: got %0d want 3", la); end
    n_vec++; if (imem_a[0] !== 32'h0000_0013) begin n_err++; $display("FAIL boot_imem0: got %h want 00000013", imem_a[0]); end
    n_vec++; if (imem_a[1] !== 32'h0010_0093) begin n_err++; $display("FAIL boot_imem1: got %h want 00100093", imem_a[1]); end
    n_vec++; if (imem_a[2] !== 32'h1234_5678) begin n_err++; $display("FAIL boot_imem2: got %h want 12345678", imem_a[2]); end
    n_vec++; if (imem_a[3] !== 32'hA5C3_0F81) begin n_err++; $display("FAIL boot_imem3: got %h want a5c30f81", imem_a[3]); end
    n_vec++; if (cs_n_a !== 1'b1 || sclk_a !== 1'b0) begin n_err++; $display("FAIL boot_release: cs_n=%b sclk=%b want 1/0", cs_n_a, sclk_a); end
  endtask

  task automatic test_reset_mid();
    int w1;
    bit ok;
    logic [3:0] la;
    reset_n_a = 1'b0; boot_en_a = 1'b1;
    @(negedge clk);
    reset_n_a = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (we_a === 1'b1 && addr_a === 4'd2) begin ok = 1'b1; break; end
    end
    n_vec++; if (!ok) begin n_err++; $display("FAIL mid_wait_word2: no write to addr 2 within 3000 cycles"); end
    reset_n_a = 1'b0;
    @(negedge clk);
    n_vec++; if (cs_n_a !== 1'b1 || done_a !== 1'b0) begin n_err++; $display("FAIL mid_reset_pins: cs_n=%b done=%b want 1/0", cs_n_a, done_a); end
    n_vec++; if (we_a !== 1'b0 || sclk_a !== 1'b0 || addr_a !== 4'd0) begin n_err++; $display("FAIL mid_reset_regs: we=%b sclk=%b addr=%0d want 0/0/0", we_a, sclk_a, addr_a); end
    reset_n_a = 1'b1;
    cmd_rx_a = 32'd0;
    w1 = wr_cnt_a; ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin ok = 1'b1; break; end
    end
    n_vec++; if (!ok) begin n_err++; $display("FAIL mid_restart_timeout: done=%b want 1", done_a); end
    n_vec++; if (cmd_rx_a !== 32'h0310_0000) begin n_err++; $display("FAIL mid_cmd_resent: got %h want 03100000", cmd_rx_a); end
    la = wr_log_a[w1 % 64];
    n_vec++; if (la !== 4'd0) begin n_err++; $display("FAIL mid_first_addr: got %0d want 0", la); end
    n_vec++; if (wr_cnt_a - w1 != 4) begin n_err++; $display("FAIL mid_writes: got %0d want 4", wr_cnt_a - w1); end
    n_vec++; if (imem_a[2] !== 32'h1234_5678) begin n_err++; $display("FAIL mid_imem2: got %h want 12345678", imem_a[2]); end
  endtask

  task automatic test_clkdiv3();
    bit ok;
    reset_n_b = 1'b1; ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done_b === 1'b1) begin ok = 1'b1; break; end
    end
    n_vec++; if (!ok) begin n_err++; $display("FAIL div3_timeout: done=%b want 1", done_b); end
    n_vec++; if (rise_b != 96) begin n_err++; $display("FAIL div3_rises: got %0d want 96", rise_b); end
    n_vec++; if (runs_b != 191 || runv_b != 0) begin n_err++; $display("FAIL div3_phase: runs=%0d bad=%0d want 191/0", runs_b, runv_b); end
    n_vec++; if (wr_cnt_b != 2 || wbad_b != 0) begin n_err++; $display("FAIL div3_writes: got %0d bad=%0d want 2/0", wr_cnt_b, wbad_b); end
    n_vec++; if (glitch_b != 0) begin n_err++; $display("FAIL div3_cs_low: %0d high cycles want 0", glitch_b); end
    n_vec++; if (cs_n_b !== 1'b1) begin n_err++; $display("FAIL div3_cs_release: got %b want 1", cs_n_b); end
  endtask

  task automatic test_miso_ones();
    bit ok;
    reset_n_c = 1'b1; ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done_c === 1'b1) begin ok = 1'b1; break; end
    end
    n_vec++; if (!ok) begin n_err++; $display("FAIL ones_timeout: done=%b want 1", done_c); end
    repeat (1000) @(negedge clk);
    n_vec++; if (wr_cnt_c != 8) begin n_err++; $display("FAIL ones_writes: got %0d want 8", wr_cnt_c); end
    n_vec++; if (wbad_c != 0) begin n_err++; $display("FAIL ones_data: %0d words not ffffffff want 0", wbad_c); end
    n_vec++; if (aord_c != 0) begin n_err++; $display("FAIL ones_addr_order: %0d out of order want 0", aord_c); end
    n_vec++; if (rise_c != 288) begin n_err++; $display("FAIL ones_rises: got %0d want 288", rise_c); end
    n_vec++; if (drop_c != 0 || done_c !== 1'b1) begin n_err++; $display("FAIL ones_done_sticky: drops=%0d done=%b want 0/1", drop_c, done_c); end
  endtask

  initial begin
    test_reset();
    test_skip();
    test_boot();
    test_reset_mid();
    test_clkdiv3();
    test_miso_ones();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
